// File: rtl/push_sequencer_if.sv
// Bus bundle between the control unit and the PUSH sequencer:
// start/operand inputs, memory write port, SP write-back, status.
interface push_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              i_MCycle_Tick;
  logic              i_Start;
  logic [3:0]        i_P;
  logic [15:0]       i_Reg_Data;
  logic [ADDR_W-1:0] i_SP;
  logic              i_Mem_Ready;
  logic              o_Busy;
  logic [ADDR_W-1:0] o_Address_Out;
  logic [7:0]        o_Data_Out;
  logic              o_Mem_Write;
  logic [ADDR_W-1:0] o_SP_Value;
  logic              o_SP_We;
  logic              o_IR_Fetch;
  logic              o_Done;

  modport master (
    input  i_MCycle_Tick, i_Start, i_P, i_Reg_Data,
    input  i_SP, i_Mem_Ready,
    output o_Busy, o_Address_Out, o_Data_Out, o_Mem_Write,
    output o_SP_Value, o_SP_We, o_IR_Fetch, o_Done
  );

  modport slave (
    output i_MCycle_Tick, i_Start, i_P, i_Reg_Data,
    output i_SP, i_Mem_Ready,
    input  o_Busy, o_Address_Out, o_Data_Out, o_Mem_Write,
    input  o_SP_Value, o_SP_We, o_IR_Fetch, o_Done
  );
endinterface

// File: rtl/push_sequencer.sv
// SM83 PUSH rr sequencer: runs M2 (SP dec), M3 (hi write) and
// M4 (lo write overlapped with the next IR fetch) after M1.
module push_sequencer #(
  parameter logic [7:0] F_MASK = 8'hF0,
  parameter int         ADDR_W = 16
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  push_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    DEC,
    WR_HI,
    WR_LO
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] sp_r;
  logic [7:0]        hi_r, lo_r;
  logic              accept;
  logic              sp_we;
  logic [ADDR_W-1:0] sp_dec;

  assign sp_dec = sp_r - 1'b1;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
      sp_r  <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        sp_r <= bus.i_SP;
        hi_r <= bus.i_Reg_Data[15:8];
        lo_r <= bus.i_P[3] ? (bus.i_Reg_Data[7:0] & F_MASK)
                           : bus.i_Reg_Data[7:0];
      end
      if (sp_we) sp_r <= sp_dec;
    end
  end

  // Strobes are masked while reset is asserted so a reset edge
  // never coincides with a commit, write or done.
  always_comb begin
    state_n           = state;
    accept            = 1'b0;
    sp_we             = 1'b0;
    bus.o_Busy        = 1'b0;
    bus.o_Address_Out = '0;
    bus.o_Data_Out    = '0;
    bus.o_Mem_Write   = 1'b0;
    bus.o_IR_Fetch    = 1'b0;
    bus.o_Done        = 1'b0;
    if (!i_Reset) begin
      unique case (state)
        IDLE: begin
          if (bus.i_Start && $onehot(bus.i_P)) begin
            accept  = 1'b1;
            state_n = DEC;
          end
        end
        DEC: begin
          bus.o_Busy = 1'b1;
          if (bus.i_MCycle_Tick) begin
            sp_we   = 1'b1;
            state_n = WR_HI;
          end
        end
        WR_HI: begin
          bus.o_Busy        = 1'b1;
          bus.o_Address_Out = sp_r;
          bus.o_Data_Out    = hi_r;
          bus.o_Mem_Write   = 1'b1;
          if (bus.i_MCycle_Tick && bus.i_Mem_Ready) begin
            sp_we   = 1'b1;
            state_n = WR_LO;
          end
        end
        WR_LO: begin
          bus.o_Busy        = 1'b1;
          bus.o_Address_Out = sp_r;
          bus.o_Data_Out    = lo_r;
          bus.o_Mem_Write   = 1'b1;
          bus.o_IR_Fetch    = 1'b1;
          if (bus.i_MCycle_Tick && bus.i_Mem_Ready) begin
            bus.o_Done = 1'b1;
            state_n    = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.o_SP_We    = sp_we;
  assign bus.o_SP_Value = sp_we ? sp_dec : '0;

endmodule

// File: tb/tb_push_sequencer.sv
// Randomised scoreboard bench for push_sequencer: a stack-push
// model queues expected SP commits, writes and done events.
module tb_push_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  push_sequencer_if #(.ADDR_W(16)) bus ();

  push_sequencer #(.F_MASK(8'hF0), .ADDR_W(16)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        ir;
    int          lat;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic take(input int kind, output ev_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = '{kind: 0, addr: 16'h0, data: 8'h0, ir: 1'b0, lat: 0};
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event: unexpected kind %0d, none expected", kind);
    end else if (exp_q[0].kind != kind) begin
      failures++;
      $display("FAIL event: got kind %0d expected kind %0d",
               kind, exp_q[0].kind);
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor: compares every observed commit/write/done in order
  int          lat;
  logic        pmw, pwr;
  logic [15:0] paddr;
  logic [7:0]  pdata;

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    logic wr;
    if (rst) begin
      lat = 0;
      pmw = 1'b0;
      pwr = 1'b0;
    end else begin
      if (bus.o_Busy && bus.i_MCycle_Tick) lat++;
      if (bus.o_Mem_Write && pmw && !pwr)
        chk("stall_hold", {bus.o_Address_Out, bus.o_Data_Out},
            {paddr, pdata});
      wr = bus.o_Mem_Write && bus.i_MCycle_Tick && bus.i_Mem_Ready;
      if (wr) begin
        take(1, e, ok);
        if (ok) begin
          chk("wr_addr", bus.o_Address_Out, e.addr);
          chk("wr_data", bus.o_Data_Out, e.data);
          chk("ir_fetch", bus.o_IR_Fetch, e.ir);
        end
      end
      if (bus.o_SP_We) begin
        take(0, e, ok);
        if (ok) chk("sp_value", bus.o_SP_Value, e.addr);
      end
      if (bus.o_Done) begin
        take(2, e, ok);
        if (ok) chk("latency", lat, e.lat);
      end
      pmw   = bus.o_Mem_Write;
      pwr   = wr;
      paddr = bus.o_Address_Out;
      pdata = bus.o_Data_Out;
      if (!bus.o_Busy) lat = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input bit starts);
    bus.i_Start    = starts ? 1'($urandom) : 1'b0;
    bus.i_P        = 4'($urandom);
    bus.i_Reg_Data = 16'($urandom);
    bus.i_SP       = 16'($urandom);
  endtask

  task automatic expect_push(input logic [15:0] sp,
                             input logic [15:0] data,
                             input logic [3:0] p, input int stalls);
    logic [7:0] lo;
    lo = data[7:0];
    if (p[3]) lo = {lo[7:4], 4'h0};
    exp_q.push_back('{0, sp - 16'd1, 8'h0, 1'b0, 0});
    exp_q.push_back('{1, sp - 16'd1, data[15:8], 1'b0, 0});
    exp_q.push_back('{0, sp - 16'd2, 8'h0, 1'b0, 0});
    exp_q.push_back('{1, sp - 16'd2, lo, 1'b1, 0});
    exp_q.push_back('{2, 16'h0, 8'h0, 1'b0, 3 + stalls});
  endtask

  task automatic tick(input logic rdy, input bit midstart);
    int gap;
    gap = int'($urandom_range(0, 2));
    repeat (gap) begin
      scramble(midstart);
      bus.i_Mem_Ready = 1'($urandom);
      step();
    end
    scramble(midstart);
    bus.i_MCycle_Tick = 1'b1;
    bus.i_Mem_Ready   = rdy;
    step();
    bus.i_MCycle_Tick = 1'b0;
  endtask

  task automatic push(input logic [15:0] sp, input logic [15:0] data,
                      input logic [3:0] p, input int s1, input int s2,
                      input bit midstart);
    bit legal;
    legal = $onehot(p);
    bus.i_Start    = 1'b1;
    bus.i_P        = p;
    bus.i_Reg_Data = data;
    bus.i_SP       = sp;
    if (legal) expect_push(sp, data, p, s1 + s2);
    step();
    scramble(1'b0);
    chk("busy_accept", bus.o_Busy, legal);
    if (legal) begin
      tick(1'($urandom), midstart);
      repeat (s1) tick(1'b0, midstart);
      tick(1'b1, midstart);
      repeat (s2) tick(1'b0, midstart);
      tick(1'b1, midstart);
      bus.i_Start = 1'b0;
      chk("busy_end", bus.o_Busy, 1'b0);
    end
  endtask

  task automatic check_quiet(input string name);
    chk(name, {bus.o_Busy, bus.o_Address_Out, bus.o_Data_Out,
               bus.o_Mem_Write, bus.o_SP_Value, bus.o_SP_We,
               bus.o_IR_Fetch, bus.o_Done}, '0);
  endtask

  initial begin
    logic [3:0] p;
    bus.i_MCycle_Tick = 1'b0;
    bus.i_Start       = 1'b0;
    bus.i_P           = 4'h0;
    bus.i_Reg_Data    = 16'h0;
    bus.i_SP          = 16'h0;
    bus.i_Mem_Ready   = 1'b1;
    rst               = 1'b1;
    step();
    step();
    check_quiet("reset_outputs");
    rst = 1'b0;
    step();
    check_quiet("idle_outputs");

    push(16'hFFFE, 16'h1234, 4'b0001, 0, 0, 1'b0);
    push(16'hD000, 16'hA5BF, 4'b1000, 0, 0, 1'b0);
    push(16'h0001, 16'hBEEF, 4'b0100, 0, 0, 1'b0);
    push(16'hFFFE, 16'h1234, 4'b0001, 2, 0, 1'b1);
    push(16'h8000, 16'h5555, 4'b0101, 0, 0, 1'b0);
    push(16'h8000, 16'h5555, 4'b0000, 0, 0, 1'b0);
    step();
    chk("illegal_idle", bus.o_Busy, 1'b0);

    // Reset while WR_HI is presenting, same clock as a ready tick
    bus.i_Start    = 1'b1;
    bus.i_P        = 4'b0010;
    bus.i_Reg_Data = 16'hCAFE;
    bus.i_SP       = 16'h4000;
    exp_q.push_back('{0, 16'h3FFF, 8'h0, 1'b0, 0});
    step();
    bus.i_Start = 1'b0;
    tick(1'b1, 1'b0);
    chk("wr_hi_addr", bus.o_Address_Out, 16'h3FFF);
    rst               = 1'b1;
    bus.i_MCycle_Tick = 1'b1;
    bus.i_Mem_Ready   = 1'b1;
    step();
    rst               = 1'b0;
    bus.i_MCycle_Tick = 1'b0;
    check_quiet("after_reset");
    chk("queue_after_reset", exp_q.size(), 0);
    push(16'hC000, 16'h0F0F, 4'b0010, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      p = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) p = 4'($urandom);
      push(16'($urandom), 16'($urandom), p,
           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
           1'($urandom));
    end
    step();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
